// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the sequential FPU divider.
package fpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEF_WIDTH     = 24;
    localparam int DEF_FRAC_BITS = 25;

    // Iteration counter width able to hold 0..qw.
    function automatic int cnt_width(input int qw);
        return $clog2(qw + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the exponent stage and the divider.
interface seq_divider_if
    import fpu_div_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
);
    localparam int QW = WIDTH + FRAC_BITS;

    logic             REQ;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             READY;
    logic             VALID;
    logic [QW-1:0]    Q;
    logic [WIDTH-1:0] REM;
    logic             STICKY;
    logic             DBZ;

    modport master (
        output REQ, A, B,
        input  READY, VALID, Q, REM, STICKY, DBZ
    );

    modport slave (
        input  REQ, A, B,
        output READY, VALID, Q, REM, STICKY, DBZ
    );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step; kept separate so a CLA
// implementation can replace the behavioural one.
module div_trial_sub #(
    parameter int DW = 26
) (
    input  logic [DW-1:0] minuend_i,
    input  logic [DW-1:0] subtrahend_i,
    output logic [DW-2:0] diff_o,
    output logic          neg_o
);
    logic [DW-1:0] full;

    assign full   = minuend_i - subtrahend_i;
    assign diff_o = full[DW-2:0];
    assign neg_o  = full[DW-1];

endmodule

// File: rtl/seq_divider.sv
// Restoring divider producing floor(A * 2^FRAC_BITS / B), one quotient bit per clock.
// state | meaning
// IDLE  | ready, waiting for REQ
// RUN   | iterating, cnt_q = 0..QW-1
// DONE  | VALID pulse, ready for the next REQ
module seq_divider
    import fpu_div_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic          CLK,
    input  logic          RST,
    seq_divider_if.slave  div_if
);
    localparam int QW = WIDTH + FRAC_BITS;
    localparam int CW = cnt_width(QW);
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [QW-1:0]    dividend_q, dividend_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [QW-1:0]    quot_q, quot_d;
    logic [QW-1:0]    q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sticky_q, sticky_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             neg;
    logic [WIDTH:0]   pr_nx;
    logic [QW-1:0]    quot_nx;

    // T never exceeds 2B-1, so WIDTH+1 bits of partial remainder suffice.
    assign trial = {pr_q[WIDTH-1:0], dividend_q[QW-1]};

    div_trial_sub #(.DW(WIDTH + 2)) u_trial (
        .minuend_i    ({1'b0, trial}),
        .subtrahend_i ({2'b00, divisor_q}),
        .diff_o       (diff),
        .neg_o        (neg)
    );

    assign pr_nx   = neg ? trial : diff;
    assign quot_nx = (quot_q << 1) | QW'(!neg);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        pr_d       = pr_q;
        quot_d     = quot_q;
        q_d        = q_q;
        rem_d      = rem_q;
        sticky_d   = sticky_q;
        dbz_d      = dbz_q;

        case (state_q)
            RUN: begin
                pr_d       = pr_nx;
                quot_d     = quot_nx;
                dividend_d = dividend_q << 1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    q_d      = quot_nx;
                    rem_d    = pr_nx[WIDTH-1:0];
                    sticky_d = |pr_nx;
                    dbz_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (div_if.REQ) begin
                    divisor_d  = div_if.B;
                    dividend_d = QW'(div_if.A) << FRAC_BITS;
                    pr_d       = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    if (div_if.B == '0) begin
                        state_d  = DONE;
                        q_d      = '1;
                        rem_d    = div_if.A;
                        sticky_d = 1'b1;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            pr_q       <= '0;
            quot_q     <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            sticky_q   <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            pr_q       <= pr_d;
            quot_q     <= quot_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            sticky_q   <= sticky_d;
            dbz_q      <= dbz_d;
        end
    end

    assign div_if.READY  = (state_q != RUN);
    assign div_if.VALID  = (state_q == DONE);
    assign div_if.Q      = q_q;
    assign div_if.REM    = rem_q;
    assign div_if.STICKY = sticky_q;
    assign div_if.DBZ    = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: default 24/25 instance plus an 8-bit integer instance.
module tb_seq_divider;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    seq_divider_if #(.WIDTH(24), .FRAC_BITS(25)) dif ();
    seq_divider_if #(.WIDTH(8),  .FRAC_BITS(0))  sif ();

    seq_divider #(.WIDTH(24), .FRAC_BITS(25)) u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .div_if (dif.slave)
    );

    seq_divider #(.WIDTH(8), .FRAC_BITS(0)) u_small (
        .CLK    (CLK),
        .RST    (RST),
        .div_if (sif.slave)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [48:0] Q1 = 49'h3000000;
    localparam logic [48:0] Q2 = 49'h1555555;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch one default-width operation; lat = edges after the accept edge until VALID.
    task automatic big_op(input logic [23:0] a, input logic [23:0] b, output int lat);
        dif.A   = a;
        dif.B   = b;
        dif.REQ = 1'b1;
        tick();
        dif.REQ = 1'b0;
        lat = 0;
        while (!dif.VALID && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic small_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        sif.A   = a;
        sif.B   = b;
        sif.REQ = 1'b1;
        tick();
        sif.REQ = 1'b0;
        lat = 0;
        while (!sif.VALID && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        checks++; if (dif.READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", dif.READY); end
        checks++; if (dif.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dif.VALID); end
        checks++; if (dif.Q !== 49'h0) begin errors++; $display("FAIL reset_q got %h want 0", dif.Q); end
        checks++; if (dif.REM !== 24'h0) begin errors++; $display("FAIL reset_rem got %h want 0", dif.REM); end
        checks++; if ({dif.STICKY, dif.DBZ} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {dif.STICKY, dif.DBZ}); end
        checks++; if (sif.READY !== 1'b1) begin errors++; $display("FAIL reset_small_ready got %b want 1", sif.READY); end
    endtask

    task automatic test_exact();
        int lat;
        dif.A = 24'hC00000; dif.B = 24'h800000; dif.REQ = 1'b1;
        tick();
        dif.REQ = 1'b0;
        checks++; if (dif.READY !== 1'b0) begin errors++; $display("FAIL exact_busy got %b want 0", dif.READY); end
        lat = 0;
        while (!dif.VALID && lat < 200) begin tick(); lat++; end
        checks++; if (lat != 49) begin errors++; $display("FAIL exact_latency got %0d want 49", lat); end
        checks++; if (dif.Q !== Q1) begin errors++; $display("FAIL exact_q got %h want %h", dif.Q, Q1); end
        checks++; if (dif.REM !== 24'h0) begin errors++; $display("FAIL exact_rem got %h want 0", dif.REM); end
        checks++; if ({dif.STICKY, dif.DBZ, dif.READY} !== 3'b001) begin errors++; $display("FAIL exact_flags got %b want 001", {dif.STICKY, dif.DBZ, dif.READY}); end
        tick();
        checks++; if (dif.VALID !== 1'b0) begin errors++; $display("FAIL exact_pulse got %b want 0", dif.VALID); end
        checks++; if (dif.Q !== Q1) begin errors++; $display("FAIL exact_hold got %h want %h", dif.Q, Q1); end
    endtask

    task automatic test_inexact();
        int lat;
        big_op(24'h800000, 24'hC00000, lat);
        checks++; if (lat != 49) begin errors++; $display("FAIL inexact_latency got %0d want 49", lat); end
        checks++; if (dif.Q !== Q2) begin errors++; $display("FAIL inexact_q got %h want %h", dif.Q, Q2); end
        checks++; if (dif.REM !== 24'h400000) begin errors++; $display("FAIL inexact_rem got %h want 400000", dif.REM); end
        checks++; if ({dif.STICKY, dif.DBZ} !== 2'b10) begin errors++; $display("FAIL inexact_flags got %b want 10", {dif.STICKY, dif.DBZ}); end
        tick();
    endtask

    task automatic test_dbz();
        int lat;
        big_op(24'h9A0000, 24'h0, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL dbz_latency got %0d edges want 0 after accept", lat); end
        checks++; if (dif.DBZ !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", dif.DBZ); end
        checks++; if (dif.Q !== {49{1'b1}}) begin errors++; $display("FAIL dbz_q got %h want all ones", dif.Q); end
        checks++; if (dif.REM !== 24'h9A0000) begin errors++; $display("FAIL dbz_rem got %h want 9a0000", dif.REM); end
        checks++; if (dif.STICKY !== 1'b1) begin errors++; $display("FAIL dbz_sticky got %b want 1", dif.STICKY); end
        tick();
        checks++; if ({dif.VALID, dif.READY} !== 2'b01) begin errors++; $display("FAIL dbz_after got %b want 01", {dif.VALID, dif.READY}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic stable;
        dif.A = 24'hC00000; dif.B = 24'h800000; dif.REQ = 1'b1;
        tick();
        lat = 0;
        while (!dif.VALID && lat < 200) begin tick(); lat++; end
        checks++; if (dif.Q !== Q1) begin errors++; $display("FAIL b2b_first_q got %h want %h", dif.Q, Q1); end
        dif.A = 24'h800000; dif.B = 24'hC00000;
        tick();
        checks++; if ({dif.VALID, dif.READY} !== 2'b00) begin errors++; $display("FAIL b2b_accept got %b want 00", {dif.VALID, dif.READY}); end
        stable = 1'b1;
        lat = 0;
        while (!dif.VALID && lat < 200) begin
            if (lat == 5) dif.REQ = 1'b0;
            if (dif.Q !== Q1 || dif.REM !== 24'h0 || dif.STICKY !== 1'b0) stable = 1'b0;
            tick();
            lat++;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_stable got %b want 1", stable); end
        checks++; if (lat != 49) begin errors++; $display("FAIL b2b_latency got %0d want 49", lat); end
        checks++; if (dif.Q !== Q2) begin errors++; $display("FAIL b2b_second_q got %h want %h", dif.Q, Q2); end
        checks++; if (dif.REM !== 24'h400000) begin errors++; $display("FAIL b2b_second_rem got %h want 400000", dif.REM); end
        tick();
        tick();
        checks++; if ({dif.VALID, dif.READY} !== 2'b01) begin errors++; $display("FAIL b2b_no_queue got %b want 01", {dif.VALID, dif.READY}); end
    endtask

    task automatic test_abort();
        int lat;
        logic seen;
        dif.A = 24'h800000; dif.B = 24'hC00000; dif.REQ = 1'b1;
        tick();
        dif.REQ = 1'b0;
        repeat (10) tick();
        checks++; if (dif.READY !== 1'b0) begin errors++; $display("FAIL abort_running got %b want 0", dif.READY); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if ({dif.READY, dif.VALID} !== 2'b10) begin errors++; $display("FAIL abort_hs got %b want 10", {dif.READY, dif.VALID}); end
        checks++; if (dif.Q !== 49'h0 || dif.REM !== 24'h0) begin errors++; $display("FAIL abort_outputs got q=%h rem=%h want 0", dif.Q, dif.REM); end
        checks++; if ({dif.STICKY, dif.DBZ} !== 2'b00) begin errors++; $display("FAIL abort_flags got %b want 00", {dif.STICKY, dif.DBZ}); end
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (dif.VALID) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b want 0", seen); end
        big_op(24'hC00000, 24'h800000, lat);
        checks++; if (lat != 49 || dif.Q !== Q1) begin errors++; $display("FAIL abort_rerun got lat=%0d q=%h want 49 %h", lat, dif.Q, Q1); end
        tick();
    endtask

    task automatic test_small();
        int lat;
        int a;
        int b;
        big_op(24'h0, 24'h1, lat);
        small_op(8'd200, 8'd7, lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL small_latency got %0d want 8", lat); end
        checks++; if (sif.Q !== 8'd28) begin errors++; $display("FAIL small_q got %0d want 28", sif.Q); end
        checks++; if (sif.REM !== 8'd4) begin errors++; $display("FAIL small_rem got %0d want 4", sif.REM); end
        checks++; if ({sif.STICKY, sif.DBZ} !== 2'b10) begin errors++; $display("FAIL small_flags got %b want 10", {sif.STICKY, sif.DBZ}); end
        tick();
        small_op(8'd55, 8'd0, lat);
        checks++; if (sif.Q !== 8'hFF || sif.REM !== 8'd55 || sif.DBZ !== 1'b1) begin errors++; $display("FAIL small_dbz got q=%h rem=%0d dbz=%b want ff 55 1", sif.Q, sif.REM, sif.DBZ); end
        tick();
        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            small_op(8'(a), 8'(b), lat);
            checks++; if (int'(sif.Q) != a / b) begin errors++; $display("FAIL sweep_q a=%0d b=%0d got %0d want %0d", a, b, sif.Q, a / b); end
            checks++; if (int'(sif.REM) != a % b) begin errors++; $display("FAIL sweep_rem a=%0d b=%0d got %0d want %0d", a, b, sif.REM, a % b); end
            checks++; if (int'(sif.Q) * b + int'(sif.REM) != a || int'(sif.REM) >= b) begin errors++; $display("FAIL sweep_identity a=%0d b=%0d got q=%0d rem=%0d", a, b, sif.Q, sif.REM); end
            checks++; if (sif.STICKY !== (a % b != 0)) begin errors++; $display("FAIL sweep_sticky a=%0d b=%0d got %b want %b", a, b, sif.STICKY, (a % b != 0)); end
            tick();
        end
    endtask

    initial begin
        RST     = 1'b1;
        dif.REQ = 1'b0; dif.A = '0; dif.B = '0;
        sif.REQ = 1'b0; sif.A = '0; sif.B = '0;
        test_reset();
        test_exact();
        test_inexact();
        test_dbz();
        test_back_to_back();
        test_abort();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised sequential restoring divider for the FPU datapath. It is the successor to the fixed 24-bit mantissa divider, generalised in operand width and fraction scaling.
- Computes Q = floor(A * 2^FRAC_BITS / B), one quotient bit per clock.
- Also returns the true remainder, a sticky bit for the rounding stage, and divide-by-zero detection.
- Sits between exponent/sign handling and the normalise/round unit.

Parameters:
WIDTH, 24, operand width in bits (unsigned A and B; mantissa including hidden bit).
FRAC_BITS, 25, number of fractional quotient bits generated. 25 = 24-bit mantissa + guard bit; 0 = plain integer divide.
QW (localparam), WIDTH+FRAC_BITS, quotient width and iteration count.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
REQ  in  1  start request; sampled only while READY=1.
A  in  WIDTH  dividend; captured on the accept edge.
B  in  WIDTH  divisor; captured on the accept edge.
READY  out  1  idle, able to accept REQ.
VALID  out  1  one-cycle pulse; Q/REM/STICKY/DBZ are valid on it and held afterwards.
Q  out  QW  quotient.
REM  out  WIDTH  final remainder, always < B when DBZ=0.
STICKY  out  1  REM != 0.
DBZ  out  1  divide by zero (B == 0).

Behaviour:
- Reset (synchronous RST=1): READY=1, VALID=0, Q=0, REM=0, STICKY=0, DBZ=0, state=IDLE, counter=0.
- RST dominates every other input.
- RST during RUN aborts the operation: no VALID pulse; READY=1 after that edge.
- States:
  - IDLE: READY=1. REQ=1 at edge E0 moves to RUN (B!=0) or DONE (B==0), and clears READY.
  - RUN: lasts exactly QW cycles, counter 0..QW-1.
  - DONE: one cycle; then back to IDLE.
- Accept edge E0:
  - latch divisor B into the divisor register;
  - dividend shift register = {A, FRAC_BITS zeros} (QW bits);
  - partial remainder PR (WIDTH+1 bits) = 0;
  - quotient register = 0.
- Each RUN cycle:
  - T = {PR[WIDTH-1:0], dividend MSB};
  - D = T - {0, divisor} (WIDTH+2-bit subtract);
  - D non-negative: PR = D[WIDTH:0], quotient bit = 1;
  - D negative: PR = T, quotient bit = 0;
  - dividend shifts left by 1; quotient shifts left, new bit enters at the LSB.
- PR width WIDTH+1 is sufficient because T ≤ 2B-1.
- Outputs are registered at the edge leaving RUN (edge E_QW):
  - Q = quotient, REM = PR[WIDTH-1:0], STICKY = |PR, DBZ = 0;
  - VALID=1 and READY=1 for the following cycle (state DONE).
- Latency: VALID is high in the cycle after edge E_QW, i.e. QW clocks after acceptance.
- VALID falls after exactly one cycle; the output registers hold until the next completion or RST.
- Divide by zero: no iteration. At E0 latch Q = all ones, REM = A, STICKY = 1, DBZ = 1. VALID=1 and READY=1 in the cycle after E0.
- Handshake:
  - REQ while READY=0 is ignored and does not queue.
  - READY=1 during the VALID cycle, so REQ held high gives back-to-back operations with no bubble. New operands are accepted on that same edge.
  - The outputs of the previous result remain stable until the next VALID.
- A or B changing after E0 has no effect.
- The quotient is exact for any A and for any B≥1: A*2^F/B < 2^QW, so no overflow is possible.

Decomposition:
- Package fpu_div_pkg:
  - state encoding IDLE/RUN/DONE (2 bits);
  - default WIDTH and FRAC_BITS constants for single precision (24/25);
  - counter-width helper, clog2(QW+1).
- One natural sub-module: div_trial_sub.
  - Combinational (WIDTH+2)-bit trial subtractor returning the difference and the sign/borrow.
  - Replaces the direct adder instance so a CLA or behavioural subtractor can be swapped in.

Test Plan:
1. Defaults, A=0xC00000, B=0x800000 -> VALID 49 clocks after accept; Q=0x3000000, REM=0, STICKY=0, DBZ=0.
2. Defaults, A=0x800000, B=0xC00000 -> Q=0x1555555, REM=0x400000, STICKY=1.
3. Defaults, A=0x9A0000, B=0 -> VALID one clock after accept; DBZ=1, Q=all ones (49 bits), REM=0x9A0000, STICKY=1.
4. REQ held high with two operand pairs (cases 1 then 2) -> second accepted on the edge ending case 1's VALID cycle. Second VALID exactly 49 clocks later with case-2 values; case-1 outputs stable in between.
5. RST asserted for one cycle at RUN cycle 10 of case 2 -> no VALID, READY=1 and all outputs zero next cycle. Then rerun case 1 -> correct result.
6. WIDTH=8, FRAC_BITS=0, A=200, B=7 -> VALID 8 clocks after accept; Q=28, REM=4, STICKY=1. Plus a random sweep against a reference model: Q*B+REM == A<<FRAC_BITS and REM<B.
